// File: rtl/regfile_param.sv
// Parametrised register file with registered reads, optional write bypass,
// a write-protected window with sticky fault flag, and a sequenced bulk clear.
module regfile_param #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int BYPASS  = 1,
    parameter int PROT_LO = 26,
    parameter int PROT_HI = 27,
    parameter int SP_IDX  = 29,
    parameter int SP_INIT = 1020
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic        [ADDR_W-1:0] ReadReg1,
    input  logic        [ADDR_W-1:0] ReadReg2,
    input  logic        [ADDR_W-1:0] WAddr,
    input  logic signed [WIDTH-1:0]  WData,
    input  logic                     RegWrite,
    input  logic                     ClearReq,
    input  logic                     FaultClr,
    output logic signed [WIDTH-1:0]  ReadData1,
    output logic signed [WIDTH-1:0]  ReadData2,
    output logic                     Busy,
    output logic                     ClearDone,
    output logic                     WriteFault
);

    localparam bit                PROT_EN = (PROT_LO <= PROT_HI);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [WIDTH-1:0]  regs [DEPTH];

    logic in_prot;
    logic wr_fault;
    logic wr_ok;

    function automatic logic [WIDTH-1:0] init_val(input int idx);
        return (idx == SP_IDX) ? WIDTH'(SP_INIT) : '0;
    endfunction

    assign in_prot  = PROT_EN && (32'(WAddr) >= 32'(PROT_LO)) && (32'(WAddr) <= 32'(PROT_HI));
    assign wr_fault = RegWrite && (WAddr != '0) && in_prot;
    // NOTE: Busy gates only the write itself; a protected attempt still faults while clearing.
    assign wr_ok    = RegWrite && (WAddr != '0) && !in_prot && !Busy;

    function automatic logic [WIDTH-1:0] read_val(input logic [ADDR_W-1:0] addr);
        if (addr == '0)
            return '0;
        if ((BYPASS != 0) && wr_ok && (WAddr == addr))
            return WData;
        return regs[addr];
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            // NOTE: the array lives in flops and must come out of reset holding init values,
            // so it is reset here rather than left to a RAM macro.
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= init_val(i);
            ReadData1  <= '0;
            ReadData2  <= '0;
            state      <= IDLE;
            clr_cnt    <= '0;
            Busy       <= 1'b0;
            ClearDone  <= 1'b0;
            WriteFault <= 1'b0;
        end else begin
            ReadData1 <= read_val(ReadReg1);
            ReadData2 <= read_val(ReadReg2);
            ClearDone <= 1'b0;

            if (wr_fault)
                WriteFault <= 1'b1;
            else if (FaultClr)
                WriteFault <= 1'b0;

            if (wr_ok)
                regs[WAddr] <= WData;

            // Clear writes never collide with normal writes: wr_ok is low while Busy.
            case (state)
                IDLE: begin
                    if (ClearReq) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        Busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    regs[clr_cnt] <= init_val(int'(clr_cnt));
                    if (clr_cnt == LAST) begin
                        state     <= IDLE;
                        Busy      <= 1'b0;
                        ClearDone <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed vector table, clear/reset sequences, randomized
// traffic against an array-based reference model, and a wide/deep parameter instance.
module tb_regfile_param;

    logic        Clk;
    logic        Reset;
    logic [4:0]  ReadReg1, ReadReg2, WAddr;
    logic [31:0] WData;
    logic        RegWrite, ClearReq, FaultClr;

    logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
    logic        b_busy, b_done, b_fault, n_busy, n_done, n_fault;

    logic [5:0]  w_rr1, w_rr2, w_waddr;
    logic [15:0] w_wdata, w_rd1, w_rd2;
    logic        w_we, w_cr, w_fc, w_busy, w_done, w_fault;

    int    n_checks = 0;
    int    n_errors = 0;
    string phase = "init";

    regfile_param #(.BYPASS(1)) u_byp (
        .Clk(Clk), .Reset(Reset), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .WAddr(WAddr), .WData(WData), .RegWrite(RegWrite), .ClearReq(ClearReq),
        .FaultClr(FaultClr), .ReadData1(b_rd1), .ReadData2(b_rd2), .Busy(b_busy),
        .ClearDone(b_done), .WriteFault(b_fault)
    );

    regfile_param #(.BYPASS(0)) u_nobyp (
        .Clk(Clk), .Reset(Reset), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .WAddr(WAddr), .WData(WData), .RegWrite(RegWrite), .ClearReq(ClearReq),
        .FaultClr(FaultClr), .ReadData1(n_rd1), .ReadData2(n_rd2), .Busy(n_busy),
        .ClearDone(n_done), .WriteFault(n_fault)
    );

    regfile_param #(.WIDTH(16), .DEPTH(64), .PROT_LO(40), .PROT_HI(47)) u_wide (
        .Clk(Clk), .Reset(Reset), .ReadReg1(w_rr1), .ReadReg2(w_rr2),
        .WAddr(w_waddr), .WData(w_wdata), .RegWrite(w_we), .ClearReq(w_cr),
        .FaultClr(w_fc), .ReadData1(w_rd1), .ReadData2(w_rd2), .Busy(w_busy),
        .ClearDone(w_done), .WriteFault(w_fault)
    );

    always #5 Clk = ~Clk;

    // Reference model: register array plus "clears remaining" counter.
    logic [31:0] m_regs [32];
    int          clear_left;
    logic [31:0] e_rd1_b, e_rd1_n, e_rd2_b, e_rd2_n;
    logic        e_busy, e_done, e_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s %s: got 0x%0h, expected 0x%0h", phase, name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++)
            m_regs[i] = (i == 29) ? 32'd1020 : 32'd0;
        clear_left = 0;
        e_rd1_b = '0; e_rd1_n = '0; e_rd2_b = '0; e_rd2_n = '0;
        e_busy = 1'b0; e_done = 1'b0; e_fault = 1'b0;
    endtask

    task automatic model_step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic cr, input logic fc);
        logic prot;
        logic ok;
        int   idx;
        prot = (wa >= 5'd26) && (wa <= 5'd27);
        ok   = we && (wa != 5'd0) && !prot && (clear_left == 0);
        e_rd1_n = (r1 == 5'd0) ? 32'd0 : m_regs[r1];
        e_rd2_n = (r2 == 5'd0) ? 32'd0 : m_regs[r2];
        e_rd1_b = (ok && wa == r1) ? wd : e_rd1_n;
        e_rd2_b = (ok && wa == r2) ? wd : e_rd2_n;
        if (we && prot)
            e_fault = 1'b1;
        else if (fc)
            e_fault = 1'b0;
        if (ok)
            m_regs[wa] = wd;
        e_done = 1'b0;
        if (clear_left != 0) begin
            idx = 32 - clear_left;
            m_regs[idx] = (idx == 29) ? 32'd1020 : 32'd0;
            clear_left--;
            e_done = (clear_left == 0);
        end else if (cr) begin
            clear_left = 32;
        end
        e_busy = (clear_left != 0);
    endtask

    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic cr, input logic fc);
        RegWrite = we; WAddr = wa; WData = wd;
        ReadReg1 = r1; ReadReg2 = r2; ClearReq = cr; FaultClr = fc;
        model_step(we, wa, wd, r1, r2, cr, fc);
        @(posedge Clk);
        #1;
        check("rd1_byp", b_rd1, e_rd1_b);
        check("rd2_byp", b_rd2, e_rd2_b);
        check("rd1_nobyp", n_rd1, e_rd1_n);
        check("rd2_nobyp", n_rd2, e_rd2_n);
        check("busy", 32'(b_busy), 32'(e_busy));
        check("busy_nobyp", 32'(n_busy), 32'(e_busy));
        check("done", 32'(b_done), 32'(e_done));
        check("done_nobyp", 32'(n_done), 32'(e_done));
        check("fault", 32'(b_fault), 32'(e_fault));
        check("fault_nobyp", 32'(n_fault), 32'(e_fault));
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic w_cycle(input logic we, input logic [5:0] wa, input logic [15:0] wd,
                           input logic [5:0] r1, input logic [5:0] r2,
                           input logic cr, input logic fc);
        w_we = we; w_waddr = wa; w_wdata = wd;
        w_rr1 = r1; w_rr2 = r2; w_cr = cr; w_fc = fc;
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        fc;
        logic [31:0] e1b;
        logic [31:0] e1n;
        logic [31:0] e2;
        logic        ef;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int busy_cnt;
        int done_cnt;

        vecs[0]  = '{1'b0, 5'd0,  32'd0,         5'd29, 5'd0,  1'b0, 32'd1020,      32'd1020,      32'd0,         1'b0};
        vecs[1]  = '{1'b1, 5'd8,  32'hFFFF_FFFB, 5'd8,  5'd29, 1'b0, 32'hFFFF_FFFB, 32'd0,         32'd1020,      1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'd0,         5'd8,  5'd0,  1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd0,         1'b0};
        vecs[3]  = '{1'b1, 5'd26, 32'd7,         5'd26, 5'd8,  1'b0, 32'd0,         32'd0,         32'hFFFF_FFFB, 1'b1};
        vecs[4]  = '{1'b0, 5'd0,  32'd0,         5'd26, 5'd27, 1'b1, 32'd0,         32'd0,         32'd0,         1'b0};
        vecs[5]  = '{1'b1, 5'd0,  32'd9,         5'd0,  5'd8,  1'b0, 32'd0,         32'd0,         32'hFFFF_FFFB, 1'b0};
        vecs[6]  = '{1'b1, 5'd26, 32'd3,         5'd0,  5'd0,  1'b0, 32'd0,         32'd0,         32'd0,         1'b1};
        vecs[7]  = '{1'b1, 5'd27, 32'd5,         5'd27, 5'd26, 1'b1, 32'd0,         32'd0,         32'd0,         1'b1};
        vecs[8]  = '{1'b1, 5'd5,  32'd123,       5'd5,  5'd8,  1'b1, 32'd123,       32'd0,         32'hFFFF_FFFB, 1'b0};
        vecs[9]  = '{1'b1, 5'd29, 32'd40,        5'd29, 5'd5,  1'b0, 32'd40,        32'd1020,      32'd123,       1'b0};
        vecs[10] = '{1'b1, 5'd31, 32'h7FFF_FFFF, 5'd31, 5'd29, 1'b0, 32'h7FFF_FFFF, 32'd0,         32'd40,        1'b0};
        vecs[11] = '{1'b1, 5'd1,  32'h8000_0000, 5'd31, 5'd31, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0};

        Clk = 1'b0;
        Reset = 1'b1;
        RegWrite = 1'b0; WAddr = '0; WData = '0; ReadReg1 = '0; ReadReg2 = '0;
        ClearReq = 1'b0; FaultClr = 1'b0;
        w_we = 1'b0; w_waddr = '0; w_wdata = '0; w_rr1 = '0; w_rr2 = '0;
        w_cr = 1'b0; w_fc = 1'b0;
        model_reset();

        // Reset state and sweep of every register
        phase = "reset";
        #16;
        Reset = 1'b0;
        check("rst_busy", 32'(b_busy), 32'd0);
        check("rst_fault", 32'(b_fault), 32'd0);
        check("rst_done", 32'(b_done), 32'd0);
        check("rst_rd1", b_rd1, 32'd0);
        for (int i = 0; i < 16; i++)
            cycle(1'b0, 5'd0, 32'd0, 5'(2 * i), 5'(2 * i + 1), 1'b0, 1'b0);

        // Directed vectors: bypass, protection, fault set/clear priority
        phase = "table";
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].r1, vecs[i].r2, 1'b0, vecs[i].fc);
            check($sformatf("vec%0d_rd1_byp", i), b_rd1, vecs[i].e1b);
            check($sformatf("vec%0d_rd1_nobyp", i), n_rd1, vecs[i].e1n);
            check($sformatf("vec%0d_rd2_byp", i), b_rd2, vecs[i].e2);
            check($sformatf("vec%0d_rd2_nobyp", i), n_rd2, vecs[i].e2);
            check($sformatf("vec%0d_fault", i), 32'(b_fault), 32'(vecs[i].ef));
        end

        // Bulk clear with a dropped write and an ignored second request
        phase = "clear";
        cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        busy_cnt = b_busy ? 1 : 0;
        done_cnt = b_done ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 2)
                cycle(1'b1, 5'd6, 32'd77, 5'd6, 5'd5, 1'b0, 1'b0);
            else if (i == 4)
                cycle(1'b0, 5'd0, 32'd0, 5'd29, 5'd5, 1'b1, 1'b0);
            else
                idle();
            if (b_busy) busy_cnt++;
            if (b_done) done_cnt++;
        end
        check("clear_busy_cycles", 32'(busy_cnt), 32'd32);
        check("clear_done_pulses", 32'(done_cnt), 32'd1);
        cycle(1'b0, 5'd0, 32'd0, 5'd5, 5'd29, 1'b0, 1'b0);
        check("clear_reg5", b_rd1, 32'd0);
        check("clear_reg29", b_rd2, 32'd1020);
        cycle(1'b0, 5'd0, 32'd0, 5'd6, 5'd8, 1'b0, 1'b0);
        check("clear_dropped_write", b_rd1, 32'd0);

        // Reset asserted at clear cycle 10
        phase = "reset_mid_clear";
        cycle(1'b1, 5'd3, 32'd55, 5'd0, 5'd0, 1'b0, 1'b0);
        cycle(1'b1, 5'd30, 32'd66, 5'd0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            idle();
        #3;
        Reset = 1'b1;
        #1;
        check("mid_busy", 32'(b_busy), 32'd0);
        check("mid_done", 32'(b_done), 32'd0);
        check("mid_rd1", b_rd1, 32'd0);
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 16; i++)
            cycle(1'b0, 5'd0, 32'd0, 5'(2 * i), 5'(2 * i + 1), 1'b0, 1'b0);

        // Randomized traffic against the model
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            cycle(1'($urandom_range(0, 1)), wa, $urandom(),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0));
        end

        // Wide/deep instance: 16-bit, 64 entries, window 40..47
        phase = "wide";
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        w_cycle(1'b1, 6'd63, 16'h7FFF, 6'd63, 6'd29, 1'b0, 1'b0);
        check("w_bypass63", 32'(w_rd1), 32'h7FFF);
        check("w_sp_init", 32'(w_rd2), 32'd1020);
        w_cycle(1'b0, 6'd0, 16'd0, 6'd63, 6'd0, 1'b0, 1'b0);
        check("w_read63", 32'(w_rd1), 32'h7FFF);
        check("w_nofault", 32'(w_fault), 32'd0);
        w_cycle(1'b1, 6'd45, 16'h1234, 6'd45, 6'd0, 1'b0, 1'b0);
        check("w_fault45", 32'(w_fault), 32'd1);
        check("w_prot45", 32'(w_rd1), 32'd0);
        w_cycle(1'b0, 6'd0, 16'd0, 6'd45, 6'd0, 1'b0, 1'b1);
        check("w_prot45_held", 32'(w_rd1), 32'd0);
        check("w_faultclr", 32'(w_fault), 32'd0);
        w_cycle(1'b0, 6'd0, 16'd0, 6'd0, 6'd0, 1'b1, 1'b0);
        busy_cnt = w_busy ? 1 : 0;
        done_cnt = w_done ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            w_cycle(1'b0, 6'd0, 16'd0, 6'd0, 6'd0, 1'b0, 1'b0);
            if (w_busy) busy_cnt++;
            if (w_done) done_cnt++;
        end
        check("w_busy_cycles", 32'(busy_cnt), 32'd64);
        check("w_done_pulses", 32'(done_cnt), 32'd1);
        w_cycle(1'b0, 6'd0, 16'd0, 6'd63, 6'd29, 1'b0, 1'b0);
        check("w_cleared63", 32'(w_rd1), 32'd0);
        check("w_cleared_sp", 32'(w_rd2), 32'd1020);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the pipelined MIPS datapath. It is the successor to the current 32×32 register file and keeps that block's role: decode-stage operand reads and write-back-stage writes. It adds configurable width and depth, fully synchronous posedge reads, optional write-to-read bypass, a parametrised write-protected register window with a sticky fault flag, and a sequenced bulk-clear engine.

## Interface
Parameters:
- WIDTH, 32, data word width in bits
- DEPTH, 32, number of registers; power of two, at least 32
- ADDR_W, $clog2(DEPTH), register address width; derived, do not override
- BYPASS, 1, when 1 a same-cycle write is forwarded to a matching read port
- PROT_LO, 26, first write-protected register index
- PROT_HI, 27, last write-protected register index; PROT_LO > PROT_HI disables protection
- SP_IDX, 29, stack-pointer register index
- SP_INIT, 1020, stack-pointer initial value

Ports:
- Clk  in  1  clock; all state changes on posedge
- Reset  in  1  asynchronous, active-high reset
- ReadReg1  in  ADDR_W  read address, port 1
- ReadReg2  in  ADDR_W  read address, port 2
- WAddr  in  ADDR_W  write address
- WData  in  WIDTH  write data (signed)
- RegWrite  in  1  write enable
- ClearReq  in  1  single-cycle request to start a bulk clear
- FaultClr  in  1  clears WriteFault
- ReadData1  out  WIDTH  registered read data, port 1 (signed)
- ReadData2  out  WIDTH  registered read data, port 2 (signed)
- Busy  out  1  high while a bulk clear is running
- ClearDone  out  1  one-cycle pulse when a bulk clear completes
- WriteFault  out  1  sticky flag: a protected write was attempted

## Operation
Init value:
- Every register has an init value: SP_IDX holds SP_INIT, all other registers hold 0.

Reset (asynchronous):
- Every register is loaded with its init value.
- ReadData1 = ReadData2 = 0, Busy = 0, ClearDone = 0, WriteFault = 0.
- The FSM goes to IDLE and the clear counter is 0.

Write qualification:
- A write is permitted when all of the following hold: RegWrite = 1, WAddr ≠ 0, WAddr is outside [PROT_LO, PROT_HI], and Busy = 0.
- A permitted write updates Registers[WAddr] on the posedge.

Write faults:
- RegWrite = 1 with WAddr inside the protected window sets WriteFault. This applies even while Busy is high.
- A write to register 0 is dropped silently and does not set WriteFault.
- A write attempted while Busy is high and outside the protected window is dropped silently.
- FaultClr = 1 clears WriteFault. If a fault occurs in the same cycle as FaultClr, set wins.

Reads:
- On each posedge, ReadDataN ← Registers[ReadRegN].
- Register 0 always reads as 0.
- Protected registers are readable.
- Bypass (BYPASS = 1 only): if a permitted write in the same cycle has WAddr = ReadRegN, then ReadDataN ← WData.
- With BYPASS = 0, a same-cycle read returns the old value.

Clear FSM, states IDLE and CLEAR:
- IDLE → CLEAR when ClearReq = 1. Counter ← 0, Busy ← 1 on that edge.
- In CLEAR, each posedge writes Registers[counter] ← init value, then counter increments.
- When counter = DEPTH−1, that register is written, then the FSM returns to IDLE, Busy ← 0, and ClearDone ← 1 for exactly one cycle.
- ClearReq while in CLEAR is ignored.
- During CLEAR, reads continue normally. A read returns the value before this edge's clear write; bypass is not applied to clear writes.
- Reset asserted mid-clear aborts the sequence immediately and applies the full reset state.
- The counter is ADDR_W bits wide and does not wrap beyond DEPTH−1.

## Timing
- Read latency: 1 cycle. An address presented before edge N gives data valid after edge N.
- Write latency: 1 cycle. Data written at edge N is visible to a read sampled at edge N+1. With BYPASS = 1 it is also visible at edge N itself.
- Bulk clear: the ClearReq edge plus DEPTH clearing edges. Busy is high for exactly DEPTH cycles. ClearDone rises on the same edge at which Busy falls.
- WriteFault is set on the edge of the faulting write.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset sweep: assert Reset, then read every register → reg 29 = 1020, all others 0; Busy = 0, WriteFault = 0.
- Write/read with bypass: write 8 ← −5, reading reg 8 in the same cycle → ReadData1 = −5 one edge later (BYPASS = 1). Repeat with BYPASS = 0 → 0 at that edge, −5 on the following edge.
- Protection: write 26 ← 7 → reg 26 stays 0 and WriteFault = 1. Write 0 ← 9 → reg 0 reads 0 and no new fault. Assert FaultClr in the same cycle as a new write to 27 → WriteFault stays 1.
- Bulk clear: set reg 5 = 123 and reg 29 = 40, pulse ClearReq → Busy high for 32 cycles, one ClearDone pulse; afterwards reg 5 = 0 and reg 29 = 1020. A write issued during Busy is dropped; a second ClearReq during Busy is ignored.
- Reset mid-clear: assert Reset at clear cycle 10 → Busy = 0 immediately, no ClearDone pulse, all registers at their init values.
- Parameter sweep: WIDTH = 16, DEPTH = 64, PROT_LO = 40, PROT_HI = 47 → write 63 ← 0x7FFF and read it back; a write to 45 sets WriteFault; clear takes 64 cycles.
